// File: rtl/hazard_unit.sv
// Pipeline hazard control: stalls, flushes, EX forwarding and MUL/DIV hold FSM.
// Define HAZARD_FORWARDING_EN to forward from MEM/WB; otherwise RAW hazards stall in ID.
module hazard_unit #(
  parameter int MULDIV_LATENCY = 32,
  parameter int CNT_W          = $clog2(MULDIV_LATENCY + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic [4:0] e_rs1,
  input  logic [4:0] e_rs2,
  input  logic [4:0] e_rd,
  input  logic       e_mem_read,
  input  logic       e_reg_write,
  input  logic [4:0] m_rd,
  input  logic       m_reg_write,
  input  logic [4:0] w_rd,
  input  logic       w_reg_write,
  input  logic       e_muldiv,
  input  logic       e_redirect,
  input  logic       mem_stall,
  output logic       f_enable,
  output logic       d_enable,
  output logic       e_enable,
  output logic       m_enable,
  output logic       d_clear,
  output logic       e_clear,
  output logic       m_clear,
  output logic [1:0] e_fwd_a,
  output logic [1:0] e_fwd_b,
  output logic       muldiv_busy,
  output logic       muldiv_done,
  output logic [1:0] fsm_state
);

  // Stage-register control: enable=0 holds the register, clear=1 loads a bubble
  // at the next clock edge; clear is only meaningful while the stage is enabled.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             muldiv_stall;
  logic             load_use;
  logic             raw_stall;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  assign muldiv_stall = (state == IDLE && e_muldiv) || (state == BUSY);

  assign load_use = e_mem_read && (e_rd != 5'd0) &&
                    ((e_rd == d_rs1) || (e_rd == d_rs2));

`ifdef HAZARD_FORWARDING_EN
  // MEM holds the younger result, so it wins over WB.
  assign fwd_a = (m_reg_write && m_rd != 5'd0 && m_rd == e_rs1) ? 2'b10 :
                 (w_reg_write && w_rd != 5'd0 && w_rd == e_rs1) ? 2'b01 : 2'b00;
  assign fwd_b = (m_reg_write && m_rd != 5'd0 && m_rd == e_rs2) ? 2'b10 :
                 (w_reg_write && w_rd != 5'd0 && w_rd == e_rs2) ? 2'b01 : 2'b00;
  assign raw_stall = 1'b0;
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{e_rs1, e_rs2, w_rd, w_reg_write};
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
  // WB is not checked: the register file writes through to a same-cycle read.
  assign raw_stall =
    (d_rs1 != 5'd0 && ((e_reg_write && e_rd == d_rs1) || (m_reg_write && m_rd == d_rs1))) ||
    (d_rs2 != 5'd0 && ((e_reg_write && e_rd == d_rs2) || (m_reg_write && m_rd == d_rs2)));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!mem_stall) begin
      case (state)
        IDLE: begin
          if (e_muldiv) begin
            cnt_nxt   = CNT_LOAD;
            state_nxt = (MULDIV_LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (cnt == CNT_ONE) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    f_enable = 1'b1;
    d_enable = 1'b1;
    e_enable = 1'b1;
    m_enable = 1'b1;
    d_clear  = 1'b0;
    e_clear  = 1'b0;
    m_clear  = 1'b0;
    e_fwd_a  = fwd_a;
    e_fwd_b  = fwd_b;
    if (reset) begin
      f_enable = 1'b0;
      d_enable = 1'b0;
      e_enable = 1'b0;
      m_enable = 1'b0;
      e_fwd_a  = 2'b00;
      e_fwd_b  = 2'b00;
    end else if (mem_stall) begin
      f_enable = 1'b0;
      d_enable = 1'b0;
      e_enable = 1'b0;
      m_enable = 1'b0;
    end else if (muldiv_stall) begin
      // Hold F/D/EX while bubbles drain into MEM.
      f_enable = 1'b0;
      d_enable = 1'b0;
      e_enable = 1'b0;
      m_clear  = 1'b1;
    end else if (e_redirect) begin
      d_clear  = 1'b1;
      e_clear  = 1'b1;
    end else if (load_use || raw_stall) begin
      f_enable = 1'b0;
      d_enable = 1'b0;
      e_clear  = 1'b1;
    end
  end

  assign muldiv_busy = !reset && muldiv_stall;
  assign muldiv_done = !reset && (state == DONE);
  assign fsm_state   = state;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with literal expectations, then random
// traffic checked every cycle against a stall-count model of the MUL/DIV hold.
module tb_hazard_unit;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
  logic       e_mem_read, e_reg_write, m_reg_write, w_reg_write;
  logic       e_muldiv, e_redirect, mem_stall;
  logic       f_enable, d_enable, e_enable, m_enable;
  logic       d_clear, e_clear, m_clear;
  logic [1:0] e_fwd_a, e_fwd_b;
  logic       muldiv_busy, muldiv_done;
  logic [1:0] fsm_state;

  int checks   = 0;
  int failures = 0;

  // Model: number of stall cycles already spent on the current MUL/DIV, and a done flag.
  int md_spent = 0;
  bit md_done  = 1'b0;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  hazard_unit #(.MULDIV_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .d_rs1(d_rs1), .d_rs2(d_rs2),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .e_mem_read(e_mem_read), .e_reg_write(e_reg_write),
    .m_rd(m_rd), .m_reg_write(m_reg_write),
    .w_rd(w_rd), .w_reg_write(w_reg_write),
    .e_muldiv(e_muldiv), .e_redirect(e_redirect), .mem_stall(mem_stall),
    .f_enable(f_enable), .d_enable(d_enable), .e_enable(e_enable), .m_enable(m_enable),
    .d_clear(d_clear), .e_clear(e_clear), .m_clear(m_clear),
    .e_fwd_a(e_fwd_a), .e_fwd_b(e_fwd_b),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (!FWD) return 2'b00;
    if (m_reg_write && m_rd != 0 && m_rd == rs) return 2'b10;
    if (w_reg_write && w_rd != 0 && w_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit reads_hit(input logic [4:0] rd);
    return rd != 0 && (rd == d_rs1 || rd == d_rs2);
  endfunction

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    logic fe, de, ee, me, dc, ec, mc, busy, hz;
    logic [1:0] fa, fb;
    fe = 1; de = 1; ee = 1; me = 1; dc = 0; ec = 0; mc = 0;
    fa = model_fwd(e_rs1);
    fb = model_fwd(e_rs2);
    busy = !md_done && (md_spent > 0 || e_muldiv);
    hz = (e_mem_read && reads_hit(e_rd)) ||
         (!FWD && ((e_reg_write && reads_hit(e_rd)) || (m_reg_write && reads_hit(m_rd))));
    if (reset) begin
      fe = 0; de = 0; ee = 0; me = 0; fa = 0; fb = 0; busy = 0;
    end else if (mem_stall) begin
      fe = 0; de = 0; ee = 0; me = 0;
    end else if (busy) begin
      fe = 0; de = 0; ee = 0; mc = 1;
    end else if (e_redirect) begin
      dc = 1; ec = 1;
    end else if (hz) begin
      fe = 0; de = 0; ec = 1;
    end
    check("m_f_enable", f_enable, fe);
    check("m_d_enable", d_enable, de);
    check("m_e_enable", e_enable, ee);
    check("m_m_enable", m_enable, me);
    check("m_d_clear", d_clear, dc);
    check("m_e_clear", e_clear, ec);
    check("m_m_clear", m_clear, mc);
    check("m_e_fwd_a", e_fwd_a, fa);
    check("m_e_fwd_b", e_fwd_b, fb);
    check("m_busy", muldiv_busy, busy);
    check("m_done", muldiv_done, !reset && md_done);
    // Advance the model to the state that follows the coming clock edge.
    if (reset) begin
      md_spent = 0; md_done = 0;
    end else if (!mem_stall) begin
      if (md_done) md_done = 0;
      else if (busy) begin
        md_spent++;
        if (md_spent == L) begin md_done = 1; md_spent = 0; end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic clear_inputs();
    d_rs1 = 0; d_rs2 = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0; m_rd = 0; w_rd = 0;
    e_mem_read = 0; e_reg_write = 0; m_reg_write = 0; w_reg_write = 0;
    e_muldiv = 0; e_redirect = 0; mem_stall = 0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    clear_inputs();
    reset = 1;
    settle();
    check("rst_f_enable", f_enable, 0);
    check("rst_m_enable", m_enable, 0);
    check("rst_busy", muldiv_busy, 0);

    next_cycle(); reset = 0;
    settle();
    check("idle_f_enable", f_enable, 1);
    check("idle_d_enable", d_enable, 1);

    // Load x5 in EX, ID reads x5 as rs2.
    next_cycle(); e_mem_read = 1; e_reg_write = 1; e_rd = 5; d_rs2 = 5;
    settle();
    check("lu_f_enable", f_enable, 0);
    check("lu_d_enable", d_enable, 0);
    check("lu_e_clear", e_clear, 1);
    check("lu_e_enable", e_enable, 1);
    next_cycle(); e_mem_read = 0; e_reg_write = 0; e_rd = 0; m_rd = 5; m_reg_write = 1;
    settle();
    check("lu_after_f_enable", f_enable, FWD ? 1 : 0);

    // Forwarding select from MEM / WB / none.
    next_cycle(); clear_inputs();
    m_rd = 7; w_rd = 7; m_reg_write = 1; w_reg_write = 1; e_rs1 = 7;
    settle();
    check("fwd_mem", e_fwd_a, FWD ? 2'b10 : 2'b00);
    next_cycle(); m_reg_write = 0;
    settle();
    check("fwd_wb", e_fwd_a, FWD ? 2'b01 : 2'b00);
    next_cycle(); e_rs1 = 0;
    settle();
    check("fwd_x0", e_fwd_a, 2'b00);

    // MUL/DIV: L stall cycles then one DONE cycle.
    next_cycle(); clear_inputs(); e_muldiv = 1;
    for (int i = 0; i < L; i++) begin
      settle();
      check("md_busy", muldiv_busy, 1);
      check("md_m_clear", m_clear, 1);
      check("md_f_enable", f_enable, 0);
      next_cycle();
    end
    settle();
    check("md_done", muldiv_done, 1);
    check("md_done_busy", muldiv_busy, 0);
    check("md_done_e_enable", e_enable, 1);
    check("md_done_m_clear", m_clear, 0);
    next_cycle(); e_muldiv = 0;
    settle();
    check("md_after_done", muldiv_done, 0);

    // MUL/DIV with a 2-cycle mem_stall mid-BUSY: done moves 2 cycles later.
    next_cycle(); e_muldiv = 1;
    for (int c = 0; c <= L + 2; c++) begin
      mem_stall = (c == 2 || c == 3);
      settle();
      if (c < L + 2) begin
        check("mds_busy", muldiv_busy, 1);
        check("mds_done", muldiv_done, 0);
      end else begin
        check("mds_done_late", muldiv_done, 1);
      end
      if (c == 2) begin
        check("mds_m_enable", m_enable, 0);
        check("mds_m_clear", m_clear, 0);
      end
      next_cycle();
    end
    e_muldiv = 0;

    // Redirect beats a simultaneous load-use.
    clear_inputs(); e_redirect = 1; e_mem_read = 1; e_reg_write = 1; e_rd = 4; d_rs1 = 4;
    settle();
    check("rd_d_clear", d_clear, 1);
    check("rd_e_clear", e_clear, 1);
    check("rd_f_enable", f_enable, 1);

    // Reset while BUSY with two counts left.
    next_cycle(); clear_inputs(); e_muldiv = 1;
    next_cycle();
    next_cycle(); reset = 1;
    settle();
    check("rb_busy", muldiv_busy, 0);
    check("rb_m_clear", m_clear, 0);
    next_cycle(); reset = 0; e_muldiv = 0;
    settle();
    check("rb_after_busy", muldiv_busy, 0);
    check("rb_after_f_enable", f_enable, 1);

    // RAW on the EX result.
    next_cycle(); clear_inputs(); e_rd = 3; e_reg_write = 1; d_rs1 = 3; e_rs1 = 3;
    settle();
    check("raw_f_enable", f_enable, FWD ? 1 : 0);
    check("raw_e_clear", e_clear, FWD ? 0 : 1);
    check("raw_fwd_a", e_fwd_a, 2'b00);

    // Random traffic over a small register window to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      reset       = ($urandom_range(0, 199) == 0);
      d_rs1       = 5'($urandom_range(0, 7));
      d_rs2       = 5'($urandom_range(0, 7));
      e_rs1       = 5'($urandom_range(0, 7));
      e_rs2       = 5'($urandom_range(0, 7));
      e_rd        = 5'($urandom_range(0, 7));
      m_rd        = 5'($urandom_range(0, 7));
      w_rd        = 5'($urandom_range(0, 7));
      e_mem_read  = ($urandom_range(0, 3) == 0);
      e_reg_write = ($urandom_range(0, 1) == 0);
      m_reg_write = ($urandom_range(0, 1) == 0);
      w_reg_write = ($urandom_range(0, 1) == 0);
      e_muldiv    = ($urandom_range(0, 7) == 0);
      e_redirect  = ($urandom_range(0, 7) == 0);
      mem_stall   = ($urandom_range(0, 5) == 0);
    end

    next_cycle(); clear_inputs(); reset = 0;
    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

- Pipeline control block that drives the `clear`/`enable` inputs of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use and RAW hazards, flushes on taken branches/jumps, freezes the pipeline on data-memory wait, and generates EX-stage forwarding selects.
- Owns a small FSM/counter that holds a multi-cycle MUL/DIV instruction in EX for a fixed latency while bubbles drain into MEM.

## Interface
Parameters:
- `MULDIV_LATENCY`, 32, cycles a MUL/DIV instruction stalls in EX (legal range ≥1).
- `CNT_W`, `$clog2(MULDIV_LATENCY+1)`, counter width.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `d_rs1`, `d_rs2`  in  5  source registers of the instruction in ID
- `e_rs1`, `e_rs2`, `e_rd`  in  5  register fields of the instruction in EX
- `e_mem_read`, `e_reg_write`  in  1  EX instruction is a load / writes rd
- `m_rd`  in  5; `m_reg_write`  in  1  MEM-stage destination and write flag
- `w_rd`  in  5; `w_reg_write`  in  1  WB-stage destination and write flag
- `e_muldiv`  in  1  EX holds a MUL/DIV instruction
- `e_redirect`  in  1  EX resolved a taken branch or jump
- `mem_stall`  in  1  data memory not ready
- `f_enable`, `d_enable`, `e_enable`, `m_enable`  out  1  stage-register enables
- `d_clear`, `e_clear`, `m_clear`  out  1  stage-register clears
- `e_fwd_a`, `e_fwd_b`  out  2  operand select: 00 = regfile, 01 = WB, 10 = MEM
- `muldiv_busy`, `muldiv_done`  out  1  FSM status

## Operation
- Default: all enables 1, all clears 0, forwards 00.
- Priority, highest first: reset, `mem_stall`, MUL/DIV stall, redirect, load-use/RAW stall.
- `mem_stall`: all enables 0, all clears 0, FSM state and counter hold.
- MUL/DIV stall, active when (IDLE && `e_muldiv`) or BUSY: `f_enable`=`d_enable`=`e_enable`=0, `m_clear`=1.
- Redirect (`e_redirect`): `d_clear`=1, `e_clear`=1, `f_enable`=1. Overrides load-use/RAW because the ID instruction is squashed.
- Load-use: `e_mem_read` && `e_rd`≠0 && (`e_rd`==`d_rs1` || `e_rd`==`d_rs2`) gives `f_enable`=`d_enable`=0 and `e_clear`=1.
- Forwarding for each of `e_rs1`/`e_rs2`:
  - 10 if `m_reg_write` && `m_rd`≠0 && `m_rd`==rs;
  - else 01 if `w_reg_write` && `w_rd`≠0 && `w_rd`==rs;
  - else 00.
  - MEM takes priority over WB. x0 is never forwarded.
- FSM states IDLE, BUSY, DONE:
  - IDLE → BUSY on `e_muldiv` (not stalled), loading `cnt` = `MULDIV_LATENCY`-1. If `MULDIV_LATENCY`==1, go IDLE → DONE directly.
  - BUSY: when `cnt`==1 go DONE, else `cnt`--.
  - DONE → IDLE unconditionally. During DONE, `e_muldiv` is ignored and the pipeline advances, so the instruction leaves EX.
  - `muldiv_busy` = stall condition above; `muldiv_done` = (state==DONE).

## Timing
- All control outputs are combinational from inputs and FSM state; no added latency.
- A MUL/DIV instruction stalls exactly `MULDIV_LATENCY` cycles and occupies EX for `MULDIV_LATENCY`+1 cycles. It inserts `MULDIV_LATENCY` bubbles into MEM.
- Back-to-back MUL/DIV: the second instruction enters EX at the end of DONE and starts from IDLE on the next cycle.
- Load-use inserts exactly 1 bubble.
- Reset values:
  - state IDLE, `cnt`=0;
  - while `reset` is high: all enables 0, all clears 0, forwards 00, `muldiv_busy`=`muldiv_done`=0.
- Reset mid-BUSY aborts to IDLE immediately.
- A `mem_stall` arriving mid-BUSY extends the total stall by its duration; `cnt` does not decrement while it is high.

## Configuration
- `HAZARD_FORWARDING_EN` defined: forwarding as described.
- Undefined: `e_fwd_a`/`e_fwd_b` are tied to 00, and a RAW stall replaces forwarding.
  - Stall condition: `d_rs1`/`d_rs2` (≠0) matches `e_rd` with `e_reg_write`, or `m_rd` with `m_reg_write`.
  - Action: `f_enable`=`d_enable`=0, `e_clear`=1, same priority as load-use.
  - WB is not checked; the register file is write-through.

## Test plan
- Load x5 in EX, `d_rs2`=5 → one cycle of `f_enable`=`d_enable`=0, `e_clear`=1, then all enables 1.
- `m_rd`=`w_rd`=7, both writing, `e_rs1`=7 → `e_fwd_a`=10; `m_reg_write`=0 → 01; `e_rs1`=0 → 00.
- `MULDIV_LATENCY`=4, `e_muldiv`=1:
  - 4 cycles of `muldiv_busy`=1 and `m_clear`=1, then 1 cycle of `muldiv_done`=1 with all enables 1;
  - `mem_stall` pulsed for 2 cycles mid-BUSY → done occurs 2 cycles later.
- `e_redirect`=1 with a simultaneous load-use match → `d_clear`=`e_clear`=1, `f_enable`=1.
- `reset` asserted in BUSY with `cnt`=2 → next cycle state IDLE, `muldiv_busy`=0 once `e_muldiv`=0.
- `HAZARD_FORWARDING_EN` undefined, `e_rd`=3 writing, `d_rs1`=3 → stall bubble; `e_fwd_a` stays 00.
